io_ring_pwr_seq: RTL

Power-up/power-down sequencer for one IO-ring segment of the GF22FDX EG1D80V pad library. It drives the enables for the VDDIO (1.8 V pad) supply and the VDDX (pad core-side) supply, and owns pad isolation. It waits on each domain's power-good with a timeout. It sits in the chip top beside the pad ring, and its outputs connect to the supply-switch and isolation controls of the ring segment.

---
 rtl/io_ring_pwr_seq.sv | 108 ++++++++++
 1 files changed

// File: rtl/io_ring_pwr_seq.sv
// io_ring_pwr_seq: VDDIO/VDDX power sequencer with pad isolation for one IO-ring segment; define IO_PWR_SEQ_RET_EN to drive pad retention on ret_o
module io_ring_pwr_seq #(
  parameter int TO_W        = 16,
  parameter int TIMEOUT     = 1000,
  parameter int SETTLE      = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       up_req_i,
  input  logic       pg_vddio_i,
  input  logic       pg_vddx_i,
  input  logic       err_clr_i,
  output logic       en_vddio_o,
  output logic       en_vddx_o,
  output logic       iso_o,
  output logic       ret_o,
  output logic       ready_o,
  output logic       err_o,
  output logic [2:0] state_o
);
  typedef enum logic [2:0] {
    S_OFF    = 3'd0,
    S_UP_IO  = 3'd1,
    S_UP_X   = 3'd2,
    S_SETTLE = 3'd3,
    S_ON     = 3'd4,
    S_DN_X   = 3'd5,
    S_DN_IO  = 3'd6,
    S_ERR    = 3'd7
  } state_t;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);
  localparam logic [TO_W-1:0] ST_LAST = TO_W'(SETTLE - 1);
  state_t state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_io, sync_x;
  logic [TO_W-1:0] timer_q;
  logic pg_io_s, pg_x_s, to_hit, st_hit;
  logic en_io_d, en_x_d, iso_d, ready_d, err_d;
  assign pg_io_s = sync_io[SYNC_STAGES-1];
  assign pg_x_s  = sync_x[SYNC_STAGES-1];
  assign to_hit  = timer_q == TO_LAST;
  assign st_hit  = timer_q == ST_LAST;
  assign state_o = state_q;
  // bring the asynchronous power-good inputs into the clock domain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_io <= '0;
      sync_x  <= '0;
    end else begin
      sync_io <= {sync_io[SYNC_STAGES-2:0], pg_vddio_i};
      sync_x  <= {sync_x[SYNC_STAGES-2:0], pg_vddx_i};
    end
  end
  // per-state dwell timer, restarted on every transition, saturating
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) timer_q <= '0;
    else timer_q <= (state_d != state_q) ? '0 : (&timer_q) ? timer_q : timer_q + TO_W'(1);
  end
  // next-state logic; pg arrival outranks timeout while ramping up
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_OFF:    state_d = up_req_i ? S_UP_IO : S_OFF;
      S_UP_IO:  state_d = pg_io_s ? S_UP_X : to_hit ? S_ERR : !up_req_i ? S_DN_IO : S_UP_IO;
      S_UP_X:   state_d = pg_x_s ? S_SETTLE : to_hit ? S_ERR : !up_req_i ? S_DN_X : S_UP_X;
      S_SETTLE: state_d = !(pg_io_s && pg_x_s) ? S_ERR : !up_req_i ? S_DN_X : st_hit ? S_ON : S_SETTLE;
      S_ON:     state_d = !(pg_io_s && pg_x_s) ? S_ERR : !up_req_i ? S_DN_X : S_ON;
      S_DN_X:   state_d = !pg_x_s ? S_DN_IO : to_hit ? S_ERR : S_DN_X;
      S_DN_IO:  state_d = !pg_io_s ? S_OFF : to_hit ? S_ERR : S_DN_IO;
      default:  state_d = (err_clr_i && !up_req_i) ? S_OFF : S_ERR;
    endcase
  end
  // outputs decoded from the next state so they move on the same edge as the state
  always_comb begin
    en_io_d = state_d inside {S_UP_IO, S_UP_X, S_SETTLE, S_ON, S_DN_X};
    en_x_d  = state_d inside {S_UP_X, S_SETTLE, S_ON};
    iso_d   = state_d != S_ON;
    ready_d = state_d == S_ON;
    err_d   = state_d == S_ERR;
  end
  // state and output registers; reset isolates the pads and drops the enables at once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_OFF;
      en_vddio_o <= 1'b0;
      en_vddx_o  <= 1'b0;
      iso_o      <= 1'b1;
      ready_o    <= 1'b0;
      err_o      <= 1'b0;
    end else begin
      state_q    <= state_d;
      en_vddio_o <= en_io_d;
      en_vddx_o  <= en_x_d;
      iso_o      <= iso_d;
      ready_o    <= ready_d;
      err_o      <= err_d;
    end
  end
`ifdef IO_PWR_SEQ_RET_EN
  // retention is armed when power-down starts and held until the ring is back on
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ret_o <= 1'b0;
    else ret_o <= (state_d == S_DN_X) ? 1'b1 : (state_d == S_ON) ? 1'b0 : ret_o;
  end
`else
  assign ret_o = 1'b0;
`endif
endmodule
